// File: rtl/i2c_debug_responder.sv
// i2c_debug_responder: oversampled I2C target mapping START/ADDR/REGADDR/data/STOP onto a register strobe bus.
module i2c_debug_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk_ik,
  input  logic       rst_ir,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_ob8,
  output logic [7:0] reg_wdata_ob8,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_ib8,
  output logic       busy_o,
  output logic [7:0] nack_cnt_ob8
);
  typedef enum logic [2:0] {IDLE, ADDRESS, ACK, REGADDR, WRITE, READ} state_t;
  logic [1:0] w_pin, r_m, r_s, r_f, r_d;
  logic [7:0] r_c [2];
  logic       w_rise, w_fall, w_start, w_stop, w_last;
  logic [7:0] w_byte;
  state_t     r_st, r_nxt;
  logic [2:0] r_bits;
  logic [6:0] r_sh;
  logic [7:0] r_tx, r_addr, r_wdata, r_nack;
  logic       r_oe, r_we, r_re, r_busy, r_inc, r_rack;
  assign w_pin = {sda_i, scl_i};
  // bit 0 is SCL, bit 1 is SDA; a level is accepted after FILTER_LEN equal synchronized samples
  always_ff @(posedge clk_ik)
    if (rst_ir) begin
      r_m <= '1;
      r_s <= '1;
      r_f <= '1;
      r_d <= '1;
      r_c <= '{default: '0};
    end else begin
      r_m <= w_pin;
      r_s <= r_m;
      r_d <= r_f;
      for (int k = 0; k < 2; k++)
        if (r_s[k] == r_f[k]) r_c[k] <= '0;
        else if (r_c[k] == 8'(FILTER_LEN - 1)) begin
          r_f[k] <= r_s[k];
          r_c[k] <= '0;
        end else r_c[k] <= r_c[k] + 8'd1;
    end
  assign w_rise  = r_f[0] & ~r_d[0];
  assign w_fall  = ~r_f[0] & r_d[0];
  assign w_start = r_f[0] & r_d[0] & r_d[1] & ~r_f[1];
  assign w_stop  = r_f[0] & r_d[0] & ~r_d[1] & r_f[1];
  assign w_byte  = {r_sh, r_f[1]};
  assign w_last  = r_bits == 3'd7;
  always_ff @(posedge clk_ik)
    if (rst_ir) begin
      r_st    <= IDLE;
      r_nxt   <= IDLE;
      r_bits  <= '0;
      r_sh    <= '0;
      r_tx    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_nack  <= '0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_inc   <= 1'b0;
      r_rack  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      if (r_re) r_tx <= reg_rdata_ib8;
      if (w_stop) begin
        r_st   <= IDLE;
        r_oe   <= 1'b0;
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_st   <= ADDRESS;
        r_bits <= '0;
        r_oe   <= 1'b0;
        r_busy <= 1'b0;
      end else
        case (r_st)
          ADDRESS, REGADDR, WRITE:
            if (w_rise) begin
              r_sh   <= w_byte[6:0];
              r_bits <= r_bits + 3'd1;
              if (w_last) begin
                r_st  <= ACK;
                r_inc <= r_st == WRITE;
                if (r_st == ADDRESS) begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    r_busy <= 1'b1;
                    r_re   <= w_byte[0];
                    r_nxt  <= w_byte[0] ? READ : REGADDR;
                  end else begin
                    r_st   <= IDLE;
                    r_nack <= (&r_nack) ? r_nack : r_nack + 8'd1;
                  end
                end else begin
                  r_nxt <= WRITE;
                  if (r_st == REGADDR) r_addr <= w_byte;
                  else begin
                    r_wdata <= w_byte;
                    r_we    <= 1'b1;
                  end
                end
              end
            end
          // first fall after the byte pulls SDA low, the second ends the ACK slot
          ACK:
            if (w_fall) begin
              if (!r_oe) r_oe <= 1'b1;
              else begin
                r_st   <= r_nxt;
                r_bits <= '0;
                r_rack <= 1'b0;
                r_oe   <= (r_nxt == READ) ? ~r_tx[7] : 1'b0;
                if (r_inc) r_addr <= r_addr + 8'd1;
              end
            end
          READ:
            if (w_fall) r_oe <= r_rack ? 1'b0 : ~r_tx[7];
            else if (w_rise) begin
              if (!r_rack) begin
                r_tx   <= {r_tx[6:0], 1'b0};
                r_bits <= r_bits + 3'd1;
                r_rack <= w_last;
              end else if (r_f[1]) begin
                r_st   <= IDLE;
                r_rack <= 1'b0;
                r_nack <= (&r_nack) ? r_nack : r_nack + 8'd1;
              end else begin
                r_addr <= r_addr + 8'd1;
                r_re   <= 1'b1;
                r_rack <= 1'b0;
              end
            end
          default: ;
        endcase
    end
  assign sda_oe_o      = r_oe & ~rst_ir;
  assign reg_addr_ob8  = r_addr;
  assign reg_wdata_ob8 = r_wdata;
  assign reg_we_o      = r_we;
  assign reg_re_o      = r_re;
  assign busy_o        = r_busy;
  assign nack_cnt_ob8  = r_nack;
endmodule

// File: tb/tb_i2c_debug_responder.sv
// tb_i2c_debug_responder: bit-banged I2C controller with a register-pointer model and write scoreboard.
module tb_i2c_debug_responder;
  localparam logic [6:0] DEV = 7'h42;
  localparam int Q = 100;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1, glitch_en = 1'b0;
  logic bus, sda_oe_o, reg_we_o, reg_re_o, busy_o;
  logic [7:0] reg_addr_ob8, reg_wdata_ob8, reg_rdata_ib8, nack_cnt_ob8;
  logic [7:0] ptr = 8'h00, nack_exp = 8'h00;
  logic [7:0] wbuf [4];
  logic [15:0] wq [$];
  int n_re = 0, n_oe = 0, n_chk = 0, n_fail = 0;
  assign bus = sda & ~sda_oe_o;
  assign reg_rdata_ib8 = reg_addr_ob8 ^ 8'h3C;
  always #5 clk = ~clk;
  i2c_debug_responder #(.DEV_ADDR(DEV), .FILTER_LEN(3)) dut (
    .clk_ik(clk), .rst_ir(rst), .scl_i(scl), .sda_i(bus), .sda_oe_o(sda_oe_o),
    .reg_addr_ob8(reg_addr_ob8), .reg_wdata_ob8(reg_wdata_ob8), .reg_we_o(reg_we_o),
    .reg_re_o(reg_re_o), .reg_rdata_ib8(reg_rdata_ib8), .busy_o(busy_o), .nack_cnt_ob8(nack_cnt_ob8)
  );
  always @(posedge clk) begin
    if (reg_we_o) wq.push_back({reg_addr_ob8, reg_wdata_ob8});
    if (reg_re_o) n_re <= n_re + 1;
    if (sda_oe_o) n_oe <= n_oe + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, sda_oe_o, 0);
    check({tag, "_addr"}, reg_addr_ob8, 0);
    check({tag, "_wdata"}, reg_wdata_ob8, 0);
    check({tag, "_we"}, reg_we_o, 0);
    check({tag, "_re"}, reg_re_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_nack"}, nack_cnt_ob8, 0);
  endtask
  task automatic bit_out(input logic b);
    sda = b; #Q; scl = 1'b1; #(Q/2);
    if (glitch_en && $urandom_range(1) == 1) begin
      scl = 1'b0; #10; scl = 1'b1; #(Q/2 - 10);
    end else #(Q/2);
    #Q; scl = 1'b0; #Q;
  endtask
  task automatic bit_in(output logic b);
    sda = 1'b1; #Q; scl = 1'b1; #Q; b = bus; #Q; scl = 1'b0; #Q;
  endtask
  task automatic cond_start;
    sda = 1'b1; #Q; scl = 1'b1; #Q; sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic cond_stop;
    sda = 1'b0; #Q; scl = 1'b1; #Q; sda = 1'b1; #Q;
  endtask
  task automatic send(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(s);
    ack = ~s;
  endtask
  task automatic recv(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_in(s);
      b[i] = s;
    end
    bit_out(~ack);
  endtask
  task automatic xfer_write(input logic [7:0] ra, input int n);
    logic a;
    int base;
    base = wq.size();
    cond_start;
    send({DEV, 1'b0}, a); check("wr_addr_ack", a, 1);
    check("wr_busy", busy_o, 1);
    send(ra, a); check("wr_reg_ack", a, 1);
    for (int i = 0; i < n; i++) begin
      send(wbuf[i], a); check("wr_data_ack", a, 1);
    end
    cond_stop; #(2*Q);
    check("wr_busy_idle", busy_o, 0);
    check("wr_count", wq.size() - base, n);
    for (int i = 0; i < n && base + i < wq.size(); i++)
      check("wr_pair", wq[base + i], {8'(ra + 8'(i)), wbuf[i]});
    ptr = 8'(ra + 8'(n));
    check("wr_ptr", reg_addr_ob8, ptr);
  endtask
  task automatic xfer_read(input logic set_ptr, input logic [7:0] ra, input int n);
    logic a;
    logic [7:0] b;
    cond_start;
    if (set_ptr) begin
      send({DEV, 1'b0}, a); check("rd_wr_ack", a, 1);
      send(ra, a); check("rd_reg_ack", a, 1);
      ptr = ra;
      cond_start;
    end
    send({DEV, 1'b1}, a); check("rd_addr_ack", a, 1);
    check("rd_busy", busy_o, 1);
    for (int i = 0; i < n; i++) begin
      recv(i < n - 1, b);
      check("rd_data", b, ptr ^ 8'h3C);
      if (i < n - 1) ptr = ptr + 8'd1;
    end
    nack_exp = (nack_exp == 8'hFF) ? nack_exp : nack_exp + 8'd1;
    cond_stop; #(2*Q);
    check("rd_nack_cnt", nack_cnt_ob8, nack_exp);
    check("rd_ptr", reg_addr_ob8, ptr);
    check("rd_busy_idle", busy_o, 0);
  endtask
  task automatic xfer_mismatch;
    logic a;
    logic [7:0] ad;
    int we0, re0, oe0;
    do ad = 8'($urandom); while (ad[7:1] == DEV);
    we0 = wq.size(); re0 = n_re; oe0 = n_oe;
    cond_start;
    send(ad, a); check("mm_addr_nack", a, 0);
    send(8'($urandom), a); check("mm_data_nack", a, 0);
    cond_stop; #(2*Q);
    nack_exp = (nack_exp == 8'hFF) ? nack_exp : nack_exp + 8'd1;
    check("mm_oe_never", n_oe - oe0, 0);
    check("mm_no_we", wq.size() - we0, 0);
    check("mm_no_re", n_re - re0, 0);
    check("mm_nack_cnt", nack_cnt_ob8, nack_exp);
  endtask
  task automatic xfer_abort(input logic [7:0] ra);
    logic a;
    int we0;
    we0 = wq.size();
    cond_start;
    send({DEV, 1'b0}, a); check("ab_addr_ack", a, 1);
    send(ra, a); check("ab_reg_ack", a, 1);
    for (int i = 0; i < 4; i++) bit_out(1'($urandom_range(1)));
    cond_stop; #(2*Q);
    ptr = ra;
    check("ab_no_we", wq.size() - we0, 0);
    check("ab_oe", sda_oe_o, 0);
    check("ab_busy", busy_o, 0);
    check("ab_ptr", reg_addr_ob8, ptr);
  endtask
  initial begin
    int op;
    #50;
    check_reset_outputs("reset");
    #50 rst = 1'b0;
    #(2*Q);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    xfer_write(8'h10, 2);
    xfer_read(1'b1, 8'hFF, 2);
    xfer_mismatch;
    glitch_en = 1'b1;
    wbuf[0] = 8'h3E;
    xfer_write(8'h80, 1);
    glitch_en = 1'b0;
    xfer_abort(8'h22);
    for (int t = 0; t < 10; t++) begin
      op = $urandom_range(3);
      glitch_en = 1'($urandom_range(1));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      case (op)
        0: xfer_write(8'($urandom), $urandom_range(1, 3));
        1: xfer_read(1'($urandom_range(1)), 8'($urandom), $urandom_range(1, 3));
        2: xfer_mismatch;
        default: xfer_abort(8'($urandom));
      endcase
    end
    glitch_en = 1'b0;
    cond_start;
    for (int i = 7; i >= 0; i--) bit_out(i == 0 ? 1'b0 : DEV[i-1]);
    check("ack_driving", sda_oe_o, 1);
    rst = 1'b1; #1;
    check("rst_oe_same_cycle", sda_oe_o, 0);
    scl = 1'b1; sda = 1'b1; #9;
    check_reset_outputs("midrst");
    #10 rst = 1'b0;
    ptr = 8'h00; nack_exp = 8'h00;
    #(2*Q);
    xfer_read(1'b0, 8'h00, 2);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
